// File: rtl/idli_sqi_ctrl_m.sv
// Two-port SQI serial-memory controller: arbitrates a fetch port and a data port onto one
// quad-SPI bus, issuing read/write bursts and keeping CS low briefly for sequential words.
module idli_sqi_ctrl_m #(
    parameter int CONT_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p0_req,
    input  logic [15:0] i_p0_addr,
    output logic        o_p0_ack,
    output logic [15:0] o_p0_rdata,
    input  logic        i_p1_req,
    input  logic        i_p1_wr,
    input  logic [15:0] i_p1_addr,
    input  logic [15:0] i_p1_wdata,
    output logic        o_p1_ack,
    output logic [15:0] o_p1_rdata,
    output logic        o_sqi_sck,
    output logic        o_sqi_cs,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_sio_en,
    input  logic [3:0]  i_sqi_sio
);

    typedef enum logic [2:0] {IDLE, FLUSH_L, FLUSH_H, SHIFT, CONT, END} state_t;

    state_t      state_reg, state_next;
    logic        sck_reg, sck_next;
    logic        cs_reg, cs_next;
    logic [3:0]  sio_reg, sio_next;
    logic        sio_en_reg, sio_en_next;
    logic [3:0]  nib_reg, nib_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        port_reg, port_next;
    logic        wr_reg, wr_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic        last_reg, last_next;
    logic [15:0] shift_reg, shift_next;
    logic [15:0] p0_rdata_reg, p0_rdata_next;
    logic [15:0] p1_rdata_reg, p1_rdata_next;
    logic        p0_ack_reg, p0_ack_next;
    logic        p1_ack_reg, p1_ack_next;

    logic        gnt1;
    logic        own_req, other_req, own_wr, seq;
    logic [15:0] own_addr;
    logic [3:0]  hdr_len, last_nib;
    logic [39:0] tx_vec;
    logic [3:0]  tx_nib [10];

    // Tie goes to whichever port was not granted last.
    assign gnt1      = i_p1_req && (!i_p0_req || !last_reg);
    assign own_req   = port_reg ? i_p1_req : i_p0_req;
    assign other_req = port_reg ? i_p0_req : i_p1_req;
    assign own_wr    = port_reg & i_p1_wr;
    assign own_addr  = port_reg ? i_p1_addr : i_p0_addr;
    assign seq       = own_req && (own_wr == wr_reg) && (own_addr == addr_reg + 16'd2);

    // Reads carry two dummy nibbles after the address; data follows the header.
    assign hdr_len  = wr_reg ? 4'd6 : 4'd8;
    assign last_nib = hdr_len + 4'd3;

    always_comb begin
        state_next    = state_reg;
        sck_next      = sck_reg;
        nib_next      = nib_reg;
        cnt_next      = cnt_reg;
        port_next     = port_reg;
        wr_next       = wr_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        last_next     = last_reg;
        shift_next    = shift_reg;
        p0_rdata_next = p0_rdata_reg;
        p1_rdata_next = p1_rdata_reg;
        p0_ack_next   = 1'b0;
        p1_ack_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                sck_next = 1'b0;
                if (i_p0_req || i_p1_req) begin
                    port_next  = gnt1;
                    last_next  = gnt1;
                    wr_next    = gnt1 & i_p1_wr;
                    addr_next  = gnt1 ? i_p1_addr : i_p0_addr;
                    wdata_next = i_p1_wdata;
                    state_next = FLUSH_L;
                end
            end
            FLUSH_L: begin
                sck_next   = 1'b1;
                state_next = FLUSH_H;
            end
            FLUSH_H: begin
                sck_next   = 1'b0;
                nib_next   = 4'd0;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (!sck_reg) begin
                    sck_next = 1'b1;
                    if (!wr_reg && nib_reg >= 4'd8) begin
                        shift_next = {shift_reg[11:0], i_sqi_sio};
                    end
                    if (nib_reg == last_nib) begin
                        p0_ack_next = !port_reg;
                        p1_ack_next = port_reg;
                        if (!wr_reg && !port_reg) p0_rdata_next = {shift_reg[11:0], i_sqi_sio};
                        if (!wr_reg && port_reg)  p1_rdata_next = {shift_reg[11:0], i_sqi_sio};
                    end
                end else begin
                    sck_next = 1'b0;
                    if (nib_reg == last_nib) begin
                        state_next = CONT;
                        cnt_next   = 16'(CONT_WAIT);
                    end else begin
                        nib_next = nib_reg + 4'd1;
                    end
                end
            end
            CONT: begin
                sck_next = 1'b0;
                if (other_req) begin
                    state_next = END;
                end else if (own_req) begin
                    if (seq) begin
                        state_next = SHIFT;
                        nib_next   = hdr_len;
                        addr_next  = addr_reg + 16'd2;
                        wdata_next = port_reg ? i_p1_wdata : wdata_reg;
                    end else begin
                        state_next = END;
                    end
                end else if (cnt_reg == 16'd0) begin
                    state_next = END;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            END: begin
                sck_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_vec = {(wr_next ? 8'h02 : 8'h03), addr_next, wdata_next};

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_nib
            assign tx_nib[gi] = tx_vec[(9-gi)*4 +: 4];
        end
    endgenerate

    // Pin outputs are decoded from the next state so they leave the flops cleanly.
    always_comb begin
        cs_next     = !(state_next == SHIFT || state_next == CONT);
        sio_en_next = (state_next == SHIFT) &&
                      ((nib_next < 4'd6) || (wr_next && (nib_next < 4'd10)));
        sio_next    = 4'h0;
        if (sio_en_next) sio_next = tx_nib[nib_next];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            sck_reg      <= 1'b0;
            cs_reg       <= 1'b1;
            sio_reg      <= 4'h0;
            sio_en_reg   <= 1'b0;
            nib_reg      <= 4'd0;
            cnt_reg      <= 16'd0;
            port_reg     <= 1'b0;
            wr_reg       <= 1'b0;
            addr_reg     <= 16'd0;
            wdata_reg    <= 16'd0;
            last_reg     <= 1'b0;
            shift_reg    <= 16'd0;
            p0_rdata_reg <= 16'd0;
            p1_rdata_reg <= 16'd0;
            p0_ack_reg   <= 1'b0;
            p1_ack_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sck_reg      <= sck_next;
            cs_reg       <= cs_next;
            sio_reg      <= sio_next;
            sio_en_reg   <= sio_en_next;
            nib_reg      <= nib_next;
            cnt_reg      <= cnt_next;
            port_reg     <= port_next;
            wr_reg       <= wr_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            last_reg     <= last_next;
            shift_reg    <= shift_next;
            p0_rdata_reg <= p0_rdata_next;
            p1_rdata_reg <= p1_rdata_next;
            p0_ack_reg   <= p0_ack_next;
            p1_ack_reg   <= p1_ack_next;
        end
    end

    assign o_sqi_sck    = sck_reg;
    assign o_sqi_cs     = cs_reg;
    assign o_sqi_sio    = sio_reg;
    assign o_sqi_sio_en = sio_en_reg;
    assign o_p0_ack     = p0_ack_reg;
    assign o_p1_ack     = p1_ack_reg;
    assign o_p0_rdata   = p0_rdata_reg;
    assign o_p1_rdata   = p1_rdata_reg;

endmodule
